// File: rtl/subplat_rst_pkg.sv
// Shared types and defaults for the platform reset sequencer.
//   rst_state_e : sequencer FSM states
//   *_DEF       : default parameter values used by rst_sequencer
//   cnt_width() : counter width able to hold max_count without wrapping
package subplat_rst_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    SWRST
  } rst_state_e;

  localparam int unsigned N_DOMAINS_DEF    = 4;
  localparam int unsigned STAGE_CYCLES_DEF = 16;
  localparam int unsigned SWRST_CYCLES_DEF = 8;
  localparam int unsigned WDT_CYCLES_DEF   = 1024;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/rst_wdt_timer.sv
// Watchdog kick/expire counter for the reset sequencer.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset
//   run_i    : sequencer is in RUN; counter is held at zero otherwise
//   kick_i   : restart the count; a kick on the expiry edge suppresses expiry
//   expire_o : combinational, high on the edge that times out
module rst_wdt_timer
  import subplat_rst_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int unsigned CW = cnt_width(WDT_CYCLES);

  logic [CW-1:0] cnt_q;

  always_comb begin
    expire_o = run_i && !kick_i && (cnt_q == CW'(WDT_CYCLES - 1));
  end

  // Expiry drops the sequencer out of RUN, so clearing here keeps the
  // counter from ever passing WDT_CYCLES-1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!run_i || kick_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Platform reset sequencer: releases N_DOMAINS active-low peripheral resets
// one at a time, STAGE_CYCLES apart, with a software-reset req/ack handshake.
// Optional watchdog built only when macro SUBPLAT_WDT_EN is defined.
//   clk_i       : system clock
//   rst_ni      : synchronous active-low reset
//   swrst_req_i : software reset request (level, re-armed by going low)
//   swrst_ack_o : one-cycle pulse, request accepted
//   dom_rst_no  : per-domain reset, active low, released in index order
//   ready_o     : all domains released (state RUN)
//   wdt_kick_i  : watchdog restart (unused without SUBPLAT_WDT_EN)
//   wdt_bite_o  : one-cycle pulse, watchdog expired (0 without SUBPLAT_WDT_EN)
module rst_sequencer
  import subplat_rst_pkg::*;
#(
  parameter int unsigned N_DOMAINS    = N_DOMAINS_DEF,
  parameter int unsigned STAGE_CYCLES = STAGE_CYCLES_DEF,
  parameter int unsigned SWRST_CYCLES = SWRST_CYCLES_DEF,
  parameter int unsigned WDT_CYCLES   = WDT_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 swrst_req_i,
  output logic                 swrst_ack_o,
  output logic [N_DOMAINS-1:0] dom_rst_no,
  output logic                 ready_o,
  input  logic                 wdt_kick_i,
  output logic                 wdt_bite_o
);

  localparam int unsigned CNT_MAX = (STAGE_CYCLES > SWRST_CYCLES) ? STAGE_CYCLES : SWRST_CYCLES;
  localparam int unsigned CW      = cnt_width(CNT_MAX);
  localparam int unsigned SW      = cnt_width(N_DOMAINS);

  rst_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 ack_q, ack_d;
  logic                 arm_q, arm_d;
  logic                 accept;
  logic                 expire;

`ifdef SUBPLAT_WDT_EN
  logic bite_q;

  rst_wdt_timer #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .run_i   (state_q == RUN),
    .kick_i  (wdt_kick_i),
    .expire_o(expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bite_q <= 1'b0;
    end else begin
      bite_q <= expire;
    end
  end
`else
  logic unused_kick;
  assign unused_kick = wdt_kick_i;
  assign expire      = 1'b0;
`endif

  // A request is accepted only once per low->high cycle of swrst_req_i.
  assign accept = (state_q == RUN) && swrst_req_i && arm_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      dom_q   <= '0;
      ack_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      dom_q   <= dom_d;
      ack_q   <= ack_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    dom_d   = dom_q;
    ack_d   = 1'b0;
    arm_d   = !swrst_req_i || (arm_q && !accept);

    unique case (state_q)
      HOLD: begin
        state_d = RELEASE;
        cnt_d   = '0;
        stage_d = '0;
      end
      RELEASE: begin
        if (cnt_q == CW'(STAGE_CYCLES - 1)) begin
          cnt_d   = '0;
          stage_d = stage_q + SW'(1);
          for (int unsigned i = 0; i < N_DOMAINS; i++) begin
            if (stage_q == SW'(i)) dom_d[i] = 1'b1;
          end
          if (stage_q == SW'(N_DOMAINS - 1)) begin
            state_d = RUN;
            stage_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        // Watchdog bite and accepted request share one SWRST entry.
        if (accept || expire) begin
          state_d = SWRST;
          dom_d   = '0;
          cnt_d   = '0;
          ack_d   = accept;
        end
      end
      SWRST: begin
        if (cnt_q == CW'(SWRST_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          stage_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    dom_rst_no  = dom_q;
    ready_o     = (state_q == RUN);
    swrst_ack_o = ack_q;
`ifdef SUBPLAT_WDT_EN
    wdt_bite_o  = bite_q;
`else
    wdt_bite_o  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  localparam logic [3:0] F = 4'b1111;

  typedef struct {
    int unsigned at;
    string       tag;
    logic [6:0]  exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       swrst_req_i = 1'b0;
  logic       swrst_ack_o;
  logic [3:0] dom_rst_no;
  logic       ready_o;
  logic       wdt_kick_i = 1'b0;
  logic       wdt_bite_o;

  int unsigned g = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_cnt = 0;
  int          bite_cnt = 0;
  exp_t        sb[$];

  rst_sequencer #(
    .N_DOMAINS   (4),
    .STAGE_CYCLES(16),
    .SWRST_CYCLES(8),
    .WDT_CYCLES  (1024)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .swrst_req_i(swrst_req_i),
    .swrst_ack_o(swrst_ack_o),
    .dom_rst_no (dom_rst_no),
    .ready_o    (ready_o),
    .wdt_kick_i (wdt_kick_i),
    .wdt_bite_o (wdt_bite_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) g <= g + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, g);
  endtask

  task automatic push(input int unsigned at, input string tag, input logic [3:0] dom,
                      input logic rdy, input logic ack, input logic bite);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = {dom, rdy, ack, bite};
    sb.push_back(e);
  endtask

  // Inputs set after goto(t) are sampled at edge t+1.
  task automatic goto(input int unsigned t);
    while (g < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (swrst_ack_o === 1'b1) ack_cnt++;
    if (wdt_bite_o === 1'b1) bite_cnt++;
    while (sb.size() > 0 && sb[0].at <= g) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at != g) check_eq({e.tag, "_order"}, g, e.at);
      else check_eq(e.tag, {25'd0, dom_rst_no, ready_o, swrst_ack_o, wdt_bite_o},
                    {25'd0, e.exp});
    end
  end

  initial begin
    int unsigned e0, s0, r0, t0, rb, k, x;
    int a0, b0;

    // Power-up sequence
    push(3, "reset_state", 4'b0000, 0, 0, 0);
    goto(3);
    rst_ni = 1'b1;
    e0 = g + 1;
    push(e0,      "pu_e0",  4'b0000, 0, 0, 0);
    push(e0 + 15, "pu_e15", 4'b0000, 0, 0, 0);
    push(e0 + 16, "pu_e16", 4'b0001, 0, 0, 0);
    push(e0 + 31, "pu_e31", 4'b0001, 0, 0, 0);
    push(e0 + 32, "pu_e32", 4'b0011, 0, 0, 0);
    push(e0 + 48, "pu_e48", 4'b0111, 0, 0, 0);
    push(e0 + 63, "pu_e63", 4'b0111, 0, 0, 0);
    push(e0 + 64, "pu_e64", F,       1, 0, 0);
    goto(e0 + 70);

    // Single-cycle software reset
    s0 = g + 1;
    push(s0,      "sw_s0",  4'b0000, 0, 1, 0);
    push(s0 + 1,  "sw_s1",  4'b0000, 0, 0, 0);
    push(s0 + 23, "sw_s23", 4'b0000, 0, 0, 0);
    push(s0 + 24, "sw_s24", 4'b0001, 0, 0, 0);
    push(s0 + 71, "sw_s71", 4'b0111, 0, 0, 0);
    push(s0 + 72, "sw_s72", F,       1, 0, 0);
    swrst_req_i = 1'b1;
    goto(s0);
    swrst_req_i = 1'b0;
    goto(s0 + 80);

    // Held request, re-arm, requests during RELEASE
    a0 = ack_cnt;
    r0 = g + 1;
    push(r0,       "held_ack", 4'b0000, 0, 1, 0);
    push(r0 + 72,  "held_rdy", F,       1, 0, 0);
    push(r0 + 149, "held_run", F,       1, 0, 0);
    swrst_req_i = 1'b1;
    goto(r0 + 149);
    check_eq("held_one_ack", ack_cnt - a0, 1);
    swrst_req_i = 1'b0;
    goto(g + 2);
    t0 = g + 1;
    push(t0, "rearm_ack", 4'b0000, 0, 1, 0);
    swrst_req_i = 1'b1;
    goto(t0);
    swrst_req_i = 1'b0;
    goto(t0 + 12);
    swrst_req_i = 1'b1;
    goto(t0 + 13);
    swrst_req_i = 1'b0;
    push(t0 + 72,  "relreq_rdy", F, 1, 0, 0);
    push(t0 + 100, "relreq_run", F, 1, 0, 0);
    goto(t0 + 100);
    check_eq("rearm_acks", ack_cnt - a0, 2);

    // Reset mid-operation
    rst_ni = 1'b0;
    goto(g + 2);
    rst_ni = 1'b1;
    e0 = g + 1;
    push(e0 + 39, "mid_e39", 4'b0011, 0, 0, 0);
    push(e0 + 40, "mid_rst", 4'b0000, 0, 0, 0);
    goto(e0 + 39);
    rst_ni = 1'b0;
    goto(e0 + 41);
    rst_ni = 1'b1;
    e0 = g + 1;
    push(e0 + 15, "re_e15", 4'b0000, 0, 0, 0);
    push(e0 + 16, "re_e16", 4'b0001, 0, 0, 0);
    push(e0 + 64, "re_e64", F,       1, 0, 0);
    goto(e0 + 64);

`ifdef SUBPLAT_WDT_EN
    // Watchdog expiry with no kick
    a0 = ack_cnt;
    push(e0 + 1087, "wdt_pre",  F,       1, 0, 0);
    push(e0 + 1088, "wdt_bite", 4'b0000, 0, 0, 1);
    push(e0 + 1089, "wdt_end",  4'b0000, 0, 0, 0);
    push(e0 + 1112, "wdt_d0",   4'b0001, 0, 0, 0);
    push(e0 + 1160, "wdt_rdy",  F,       1, 0, 0);
    goto(e0 + 1160);
    check_eq("wdt_no_ack", ack_cnt - a0, 0);

    // Periodic kicks keep the watchdog quiet
    rb = e0 + 1160;
    b0 = bite_cnt;
    for (int unsigned i = 1; i <= 3; i++) begin
      goto(rb + 1000 * i - 1);
      wdt_kick_i = 1'b1;
      goto(rb + 1000 * i);
      wdt_kick_i = 1'b0;
    end
    k = rb + 3000;
    check_eq("kick_no_bite", bite_cnt - b0, 0);

    // Kick on the expiry edge wins
    push(k + 1030, "kick_exp_run", F, 1, 0, 0);
    goto(k + 1023);
    wdt_kick_i = 1'b1;
    goto(k + 1024);
    wdt_kick_i = 1'b0;
    goto(k + 1030);
    check_eq("kick_exp_bites", bite_cnt - b0, 0);

    // Bite and request on the same edge
    a0 = ack_cnt;
    x = k + 2048;
    push(x,      "both",     4'b0000, 0, 1, 1);
    push(x + 1,  "both_end", 4'b0000, 0, 0, 0);
    push(x + 23, "both_d23", 4'b0000, 0, 0, 0);
    push(x + 24, "both_d24", 4'b0001, 0, 0, 0);
    goto(x - 1);
    swrst_req_i = 1'b1;
    goto(x);
    swrst_req_i = 1'b0;
    goto(x + 30);
    check_eq("both_acks",  ack_cnt - a0, 1);
    check_eq("both_bites", bite_cnt - b0, 1);
`else
    // Without the watchdog, no kick pattern produces a bite
    push(e0 + 1100, "nowdt_run", F, 1, 0, 0);
    goto(e0 + 500);
    wdt_kick_i = 1'b1;
    goto(e0 + 501);
    wdt_kick_i = 1'b0;
    goto(e0 + 1100);
    check_eq("nowdt_bites", bite_cnt, 0);
`endif

    goto(g + 2);
    check_eq("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
